// File: rtl/sar_search_controller_pkg.sv
// Shared types for the SAR search controller: FSM states, step bound and
// the {gt, eq, lt} comparator response code.
package sar_search_controller_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    FINISH  = 2'd2
  } state_t;

  localparam int SAR_WIDTH = 4;

  // A binary search over 2^w values needs at most w+1 probes.
  function automatic int max_steps(input int w);
    return w + 1;
  endfunction

  localparam int MAX_STEPS = max_steps(SAR_WIDTH);

  typedef struct packed {
    logic gt;
    logic eq;
    logic lt;
  } resp_t;

  localparam resp_t RESP_GT = '{gt: 1'b1, eq: 1'b0, lt: 1'b0};
  localparam resp_t RESP_EQ = '{gt: 1'b0, eq: 1'b1, lt: 1'b0};
  localparam resp_t RESP_LT = '{gt: 1'b0, eq: 1'b0, lt: 1'b1};

endpackage

// File: rtl/sar_search_controller.sv
// Binary-search controller: drives a probe into an external magnitude
// comparator and narrows [lo, hi] until the target is located or excluded.
module sar_search_controller
  import sar_search_controller_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int STEP_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [WIDTH-1:0]  probe,
  input  logic              cmp_gt,
  input  logic              cmp_eq,
  input  logic              cmp_lt,
  output logic              busy,
  output logic              done,
  output logic              found,
  output logic              error,
  output logic [WIDTH-1:0]  result,
  output logic [STEP_W-1:0] steps,
  output state_t            dbg_state
);

  // Handshake: start is accepted only in IDLE (a one-cycle pulse there begins
  // a search); busy is high for every COMPARE cycle; done pulses for exactly
  // one cycle with found/error/result/steps valid, and those hold until the
  // next accepted start. start while busy or during done is ignored.

  localparam logic [WIDTH-1:0] TOP = '1;

  function automatic logic [WIDTH-1:0] midpoint(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    logic [WIDTH:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[WIDTH:1];
  endfunction

  state_t             state, state_n;
  logic [WIDTH-1:0]   probe_n, lo, lo_n, hi, hi_n, result_n;
  logic [STEP_W-1:0]  steps_n;
  logic               found_n, error_n;
  resp_t              resp;

  assign resp = '{gt: cmp_gt, eq: cmp_eq, lt: cmp_lt};

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      probe  <= '0;
      lo     <= '0;
      hi     <= '1;
      result <= '0;
      steps  <= '0;
      found  <= 1'b0;
      error  <= 1'b0;
    end else begin
      state  <= state_n;
      probe  <= probe_n;
      lo     <= lo_n;
      hi     <= hi_n;
      result <= result_n;
      steps  <= steps_n;
      found  <= found_n;
      error  <= error_n;
    end
  end

  always_comb begin
    state_n  = state;
    probe_n  = probe;
    lo_n     = lo;
    hi_n     = hi;
    result_n = result;
    steps_n  = steps;
    found_n  = found;
    error_n  = error;
    case (state)
      IDLE: begin
        if (start) begin
          lo_n     = '0;
          hi_n     = '1;
          probe_n  = midpoint('0, TOP);
          steps_n  = '0;
          found_n  = 1'b0;
          error_n  = 1'b0;
          result_n = '0;
          state_n  = COMPARE;
        end
      end
      COMPARE: begin
        steps_n = steps + STEP_W'(1);
        case (resp)
          RESP_EQ: begin
            result_n = probe;
            found_n  = 1'b1;
            state_n  = FINISH;
          end
          RESP_GT: begin
            if (probe == TOP) begin
              state_n = FINISH;
            end else begin
              lo_n = probe + WIDTH'(1);
              if (lo_n > hi) state_n = FINISH;
              else           probe_n = midpoint(lo_n, hi);
            end
          end
          RESP_LT: begin
            if (probe == '0) begin
              state_n = FINISH;
            end else begin
              hi_n = probe - WIDTH'(1);
              if (lo > hi_n) state_n = FINISH;
              else           probe_n = midpoint(lo, hi_n);
            end
          end
          default: begin
            // Zero or multiple flags: the comparator cannot be trusted.
            error_n = 1'b1;
            found_n = 1'b0;
            state_n = FINISH;
          end
        endcase
      end
      FINISH:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign busy      = (state == COMPARE);
  assign done      = (state == FINISH);
  assign dbg_state = state;

  assert property (@(posedge clk) disable iff (rst)
    32'(steps) <= max_steps(WIDTH));

endmodule

// File: tb/tb_sar_search_controller.sv
// Self-checking bench for sar_search_controller: a behavioural comparator and
// an interval-halving reference model predict every probe and final status.
module tb_sar_search_controller;
  import sar_search_controller_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] probe;
  logic       cmp_gt, cmp_eq, cmp_lt;
  logic       busy, done, found, error;
  logic [3:0] result;
  logic [2:0] steps;
  state_t     dbg_state;

  // Comparator environment: 0 = honest compare, 1 = forced flags, 2 = always lt
  logic [3:0] target;
  logic [1:0] cmp_mode;
  logic [2:0] forced_pat;

  int total = 0;
  int bad   = 0;

  logic [3:0] exp_q[$];
  logic       e_found, e_error;
  logic [3:0] e_result;
  int         e_steps;

  sar_search_controller #(.WIDTH(4), .STEP_W(3)) dut (
    .clk(clk), .rst(rst), .start(start), .probe(probe),
    .cmp_gt(cmp_gt), .cmp_eq(cmp_eq), .cmp_lt(cmp_lt),
    .busy(busy), .done(done), .found(found), .error(error),
    .result(result), .steps(steps), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  always_comb begin
    case (cmp_mode)
      2'd1:    {cmp_gt, cmp_eq, cmp_lt} = forced_pat;
      2'd2:    {cmp_gt, cmp_eq, cmp_lt} = 3'b001;
      default: {cmp_gt, cmp_eq, cmp_lt} = {target > probe, target == probe, target < probe};
    endcase
  end

  // Reference: halve the integer interval [lo, hi] until hit or empty.
  task automatic model(input logic [3:0] tgt, input logic [1:0] mode);
    int lo, hi, mid;
    exp_q.delete();
    e_found = 1'b0; e_error = 1'b0; e_result = 4'd0; e_steps = 0;
    lo = 0; hi = 15;
    if (mode == 2'd1) begin
      exp_q.push_back(4'd7);
      e_steps = 1;
      e_error = 1'b1;
    end else begin
      while (lo <= hi) begin
        mid = (lo + hi) / 2;
        exp_q.push_back(4'(mid));
        e_steps++;
        if (mode == 2'd0 && int'(tgt) == mid) begin
          e_found = 1'b1; e_result = 4'(mid);
          break;
        end
        if (mode == 2'd0 && int'(tgt) > mid) lo = mid + 1;
        else                                 hi = mid - 1;
      end
    end
  endtask

  task automatic run_search(input logic [3:0] tgt, input logic [1:0] mode,
                            input logic [2:0] pat, input bit inject_busy,
                            input bit inject_finish, input string name);
    int  cycles;
    bit  got_done;
    logic [3:0] want;
    model(tgt, mode);
    target = tgt; cmp_mode = mode; forced_pat = pat;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cycles = 0; got_done = 1'b0;
    for (int n = 1; n <= 20 && !got_done; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        got_done = 1'b1; cycles = n;
      end else begin
        total++;
        if (!busy) begin
          bad++; $display("FAIL %s busy: got %0b want 1 at cycle %0d", name, busy, n);
        end
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL %s extra_probe: got %0d want none", name, probe);
        end else begin
          want = exp_q.pop_front();
          if (probe !== want) begin
            bad++; $display("FAIL %s probe: got %0d want %0d", name, probe, want);
          end
        end
        if (inject_busy && n == 2) start = 1'b1;
      end
    end
    total++;
    if (!got_done) begin
      bad++; $display("FAIL %s timeout: got no done want done within 20 cycles", name);
      return;
    end
    total++;
    if (found !== e_found)  begin bad++; $display("FAIL %s found: got %0b want %0b", name, found, e_found); end
    total++;
    if (error !== e_error)  begin bad++; $display("FAIL %s error: got %0b want %0b", name, error, e_error); end
    total++;
    if (result !== e_result) begin bad++; $display("FAIL %s result: got %0d want %0d", name, result, e_result); end
    total++;
    if (int'(steps) != e_steps) begin bad++; $display("FAIL %s steps: got %0d want %0d", name, steps, e_steps); end
    total++;
    if (cycles != e_steps + 1) begin bad++; $display("FAIL %s latency: got %0d want %0d", name, cycles, e_steps + 1); end
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL %s missing_probes: got %0d left want 0", name, exp_q.size()); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL %s busy_at_done: got %0b want 0", name, busy); end
    if (inject_finish) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || dbg_state !== IDLE) begin
      bad++; $display("FAIL %s after_done: got done=%0b busy=%0b state=%0d want 0 0 IDLE", name, done, busy, dbg_state);
    end
    @(negedge clk);
    total++;
    if (found !== e_found || error !== e_error || result !== e_result || int'(steps) != e_steps) begin
      bad++; $display("FAIL %s hold: got f=%0b e=%0b r=%0d s=%0d want f=%0b e=%0b r=%0d s=%0d",
                      name, found, error, result, steps, e_found, e_error, e_result, e_steps);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; target = 4'd0; cmp_mode = 2'd0; forced_pat = 3'b000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    total++;
    if (probe !== 4'd0 || result !== 4'd0 || steps !== 3'd0) begin
      bad++; $display("FAIL reset_data: got p=%0d r=%0d s=%0d want 0 0 0", probe, result, steps);
    end
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || found !== 1'b0 || error !== 1'b0 || dbg_state !== IDLE) begin
      bad++; $display("FAIL reset_flags: got b=%0b d=%0b f=%0b e=%0b st=%0d want 0 0 0 0 IDLE",
                      busy, done, found, error, dbg_state);
    end
  endtask

  task automatic test_directed();
    run_search(4'd10, 2'd0, 3'b000, 1'b0, 1'b0, "target10");
    run_search(4'd15, 2'd0, 3'b000, 1'b0, 1'b0, "target15");
    run_search(4'd0,  2'd0, 3'b000, 1'b0, 1'b0, "target0");
    run_search(4'd7,  2'd0, 3'b000, 1'b0, 1'b0, "target7");
  endtask

  task automatic test_bad_response();
    logic [2:0] pats [5];
    pats = '{3'b000, 3'b101, 3'b011, 3'b110, 3'b111};
    for (int i = 0; i < 5; i++)
      run_search(4'($urandom_range(0, 15)), 2'd1, pats[i], 1'b0, 1'b0, "bad_resp");
  endtask

  task automatic test_always_lt();
    run_search(4'd9, 2'd2, 3'b000, 1'b0, 1'b0, "always_lt");
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++)
      run_search(4'($urandom_range(0, 15)), 2'd0, 3'b000, 1'($urandom_range(0, 1)),
                 1'b0, "random");
  endtask

  task automatic test_reset_during_compare();
    bit hit;
    hit = 1'b0;
    target = 4'd10; cmp_mode = 2'd0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 0; n < 10 && !hit; n++) begin
      @(negedge clk);
      if (probe == 4'd11) hit = 1'b1;
    end
    total++;
    if (!hit) begin bad++; $display("FAIL rst_mid reach: got no probe 11 want probe 11"); end
    rst = 1'b1;
    @(posedge clk); #1;
    total++;
    if (busy !== 1'b0 || probe !== 4'd0 || dbg_state !== IDLE || done !== 1'b0) begin
      bad++; $display("FAIL rst_mid state: got b=%0b p=%0d st=%0d d=%0b want 0 0 IDLE 0",
                      busy, probe, dbg_state, done);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_search(4'd10, 2'd0, 3'b000, 1'b0, 1'b0, "after_rst");
  endtask

  task automatic test_back_to_back();
    run_search(4'd13, 2'd0, 3'b000, 1'b1, 1'b1, "busy_start");
    run_search(4'd2,  2'd0, 3'b000, 1'b1, 1'b0, "b2b_a");
    run_search(4'd5,  2'd0, 3'b000, 1'b0, 1'b1, "b2b_b");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_bad_response();
    test_always_lt();
    test_random();
    test_reset_during_compare();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sar_search_controller.md
Name: sar_search_controller

Overview:
- Sequential counterpart to the 4-bit magnitude comparator. The comparator consumes two operands and produces gt/eq/lt. This block sits on the other side of that interface.
- It drives the probe operand (comparator B) and consumes the three flags. Operand A is an unknown target held elsewhere.
- It runs a binary search to find the target value. It reports the value, the number of comparisons taken, and a pass/fail status.

Parameters:
- WIDTH, 4, operand width in bits. The search range is 0 to 2^WIDTH-1.
- STEP_W, 3, width of the step counter. It must hold WIDTH+1, so 3 for WIDTH=4.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle request to begin a search. Ignored unless in IDLE.
- probe  output  WIDTH  registered operand driven to comparator B
- cmp_gt  input  1  comparator flag: target > probe
- cmp_eq  input  1  comparator flag: target == probe
- cmp_lt  input  1  comparator flag: target < probe
- busy  output  1  high while a search is in progress
- done  output  1  one-cycle pulse when a search ends
- found  output  1  valid with done: the target was located
- error  output  1  valid with done: the comparator response was not one-hot
- result  output  WIDTH  located value. Held until the next start.
- steps  output  STEP_W  comparisons taken. Held until the next start.

Behaviour:
- Reset (synchronous, active-high, overrides everything including a search in progress):
  - state goes to IDLE.
  - probe, result, steps, lo all clear to 0; hi sets to all-ones.
  - busy, done, found, error all clear to 0.
- State machine has three states: IDLE, COMPARE, FINISH.
- IDLE:
  - When start=1 at a clock edge: lo=0, hi=2^WIDTH-1, probe=(lo+hi)>>1 (7 for WIDTH=4), steps=0, and found/error/result clear. Next state is COMPARE.
  - busy is high from the cycle after start.
- COMPARE:
  - The comparator is combinational, so cmp_* are sampled at every edge while in COMPARE. Each sample increments steps.
  - Exactly cmp_eq: result=probe, found=1, go to FINISH.
  - Exactly cmp_gt:
    - If probe==2^WIDTH-1: not found, go to FINISH.
    - Otherwise lo=probe+1, and the new probe=(lo_new+hi)>>1.
  - Exactly cmp_lt:
    - If probe==0: not found, go to FINISH.
    - Otherwise hi=probe-1, and the new probe=(lo+hi_new)>>1.
  - If the updated lo > hi: not found, go to FINISH.
  - Any non-one-hot pattern (000, 011, 111, ...): error=1, found=0, go to FINISH.
- FINISH:
  - done=1 and busy=0 for exactly this one cycle. Then return to IDLE.
  - found, error, result, and steps hold until the next accepted start.
  - A start during FINISH is ignored.
- Arithmetic: lo+hi is computed in WIDTH+1 bits to avoid overflow. The midpoint rounds down.
- Latency and bounds:
  - At most WIDTH+1 comparisons (5 for WIDTH=4) with a consistent comparator.
  - Latency from start to done is steps+1 cycles after start is accepted.
- start while busy is ignored, with no restart.
- probe changes only on clock edges and is stable for the whole COMPARE cycle.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, COMPARE, FINISH);
  - a localparam for the maximum step count, WIDTH+1;
  - a 3-bit response-code typedef {gt, eq, lt} used for the one-hot check.
- No sub-module is needed; the midpoint is an inline expression.
- The bench instantiates the existing comparator, with A tied to the target register and B tied to probe.

Test Plan:
- Target 10, start -> probe sequence 7, 11, 9, 10. Then done, found=1, result=10, steps=4, error=0.
- Target 15 -> probes 7, 11, 13, 14, 15. Then found=1, result=15, steps=5 (worst case). Target 0 -> probes 7, 3, 1, 0, steps=4.
- Target 7 -> found on the first comparison, steps=1, done two cycles after the start edge.
- Bench forces cmp_*=000 -> done after 1 step, error=1, found=0. Forcing 101 gives the same result.
- Inconsistent model that always returns lt -> probes 7, 3, 1, 0. Then done, found=0, error=0, steps=4.
- Reset asserted during COMPARE (after probe 11) -> next cycle busy=0, probe=0, IDLE. A later start behaves as a fresh search. start pulsed while busy -> ignored, and the probe sequence is unchanged.
